// File: rtl/cpu_cpu_mul_pkg.sv
// cpu_cpu_mul_pkg: shared encodings and FIX-step helper for the multi-cycle multiply sequencer.
// Revision: 1.0
`default_nettype none

package cpu_cpu_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] ISSUE_N_MUL  = 3'd3;
  localparam logic [2:0] ISSUE_N_MULX = 3'd4;

  localparam logic [1:0] SH_0  = 2'd0;
  localparam logic [1:0] SH_16 = 2'd1;
  localparam logic [1:0] SH_32 = 2'd2;

  // Amount to subtract from the unsigned product to obtain the signed high word.
  function automatic logic [63:0] fix_corr(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] c;
    c = '0;
    if ((op == OP_MULXSU || op == OP_MULXSS) && a[31]) c = c + {b, 32'h0};
    if (op == OP_MULXSS && b[31]) c = c + {a, 32'h0};
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_cpu_mul16_reg.sv
// cpu_cpu_mul16_reg: 16x16 unsigned multiplier with one registered output stage.
// Revision: 1.0
`default_nettype none

module cpu_cpu_mul16_reg #(
  parameter int MUL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  output logic [2*MUL_W-1:0]   p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p <= '0;
    else          p <= {{MUL_W{1'b0}}, a} * {{MUL_W{1'b0}}, b};
  end

endmodule

`default_nettype wire

// File: rtl/cpu_cpu_mul_seq.sv
// cpu_cpu_mul_seq: 32x32 multiply sequencer built from four 16x16 partial products.
// Revision: 1.0
`default_nettype none

module cpu_cpu_mul_seq
  import cpu_cpu_mul_pkg::*;
#(
  parameter int MUL_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  logic [2:0]  state;
  logic [1:0]  issue_cnt;
  logic [1:0]  op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [1:0]  shift_q;
  logic        prod_vld;
  logic [63:0] acc;

  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] prod;
  logic [1:0]  shift_sel;
  logic [63:0] addend;
  logic [2:0]  issue_n;
  logic        issue_last;

  always_comb begin
    mul_a     = src1_q[15:0];
    mul_b     = src2_q[15:0];
    shift_sel = SH_0;
    case (issue_cnt)
      2'd1: begin mul_a = src1_q[31:16]; shift_sel = SH_16; end
      2'd2: begin mul_b = src2_q[31:16]; shift_sel = SH_16; end
      2'd3: begin mul_a = src1_q[31:16]; mul_b = src2_q[31:16]; shift_sel = SH_32; end
      default: ;
    endcase
  end

  cpu_cpu_mul16_reg #(.MUL_W(MUL_W)) u_mul16 (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (mul_a),
    .b       (mul_b),
    .p       (prod)
  );

  // The shift tag travels one cycle behind the issue so it lines up with prod.
  always_comb begin
    case (shift_q)
      SH_16:   addend = {16'h0, prod, 16'h0};
      SH_32:   addend = {prod, 32'h0};
      default: addend = {32'h0, prod};
    endcase
  end

  assign issue_n    = (op_q == OP_MUL) ? ISSUE_N_MUL : ISSUE_N_MULX;
  assign issue_last = ({1'b0, issue_cnt} + 3'd1) == issue_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      issue_cnt <= 2'd0;
      op_q      <= OP_MUL;
      src1_q    <= 32'h0;
      src2_q    <= 32'h0;
      shift_q   <= SH_0;
      prod_vld  <= 1'b0;
      acc       <= 64'h0;
    end else begin
      prod_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            src1_q    <= req_src1;
            src2_q    <= req_src2;
            acc       <= 64'h0;
            issue_cnt <= 2'd0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          prod_vld <= 1'b1;
          shift_q  <= shift_sel;
          if (prod_vld) acc <= acc + addend;
          if (issue_last) begin
            issue_cnt <= 2'd0;
            state     <= ST_DRAIN;
          end else begin
            issue_cnt <= issue_cnt + 2'd1;
          end
        end
        ST_DRAIN: begin
          acc   <= acc + addend;
          state <= ST_FIX;
        end
        ST_FIX: begin
          acc   <= acc - fix_corr(op_q, src1_q, src2_q);
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign rsp_valid  = (state == ST_DONE);
  assign rsp_result = (state != ST_DONE) ? 32'h0 :
                      (op_q == OP_MUL)   ? acc[31:0] : acc[63:32];

endmodule

`default_nettype wire

// File: tb/tb_cpu_cpu_mul_seq.sv
// tb_cpu_cpu_mul_seq: directed-vector bench for the multiply sequencer.
// Revision: 1.0
`default_nettype none

module tb_cpu_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_cpu_mul_seq #(.MUL_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; that cycle is handshake cycle 0.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit scramble);
    int lat;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    rsp_ready = 1'b1;
    check({tag, "_accept_ready"}, {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      check({tag, "_busy_ready"}, {31'h0, req_ready}, 32'h0);
      if (scramble) begin
        req_src1 = $urandom;
        req_src2 = $urandom;
        req_op   = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, rsp_result, exp);
    @(negedge clk);
    check({tag, "_idle_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    int n;
    bit seen;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_src1  = 32'h0;
    req_src2  = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("mul_basic",  2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 6, 1'b0);
    run_op("mulxuu_m1",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, 1'b0);
    run_op("mulxss_m1",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7, 1'b0);
    run_op("mulxsu_m1",  2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 1'b0);
    run_op("mulxss_min", 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7, 1'b0);
    run_op("mul_neg",    2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 6, 1'b0);
    run_op("mul_scr",    2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 6, 1'b1);
    run_op("mulxuu_scr", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 7, 1'b1);

    // Response backpressure with a queued request waiting behind it.
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_src1  = 32'h0001_0000;
    req_src2  = 32'h0003_0000;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", n, 7);
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_src1  = 32'd7;
    req_src2  = 32'd9;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_result", rsp_result, 32'h0000_0003);
      check("bp_hold_ready", {31'h0, req_ready}, 32'h0);
      check("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("bp_release_result", rsp_result, 32'h0000_0003);
    @(negedge clk);
    check("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    check("bp_idle_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_queued_busy", {31'h0, busy}, 32'h1);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_queued_latency", n, 6);
    check("bp_queued_result", rsp_result, 32'd63);
    @(negedge clk);

    // Asynchronous reset while the k2 partial product is being issued.
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_src1  = 32'h0000_1234;
    req_src2  = 32'h0000_5678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_rsp_result", rsp_result, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", {31'h0, seen}, 32'h0);
    run_op("mul_after_rst", 2'd0, 32'd3, 32'd5, 32'h0000_000F, 6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
